// File: rtl/instr_fetch_queue.sv
// Circular instruction queue between fetch and decode: accepts up to FETCH_WIDTH, presents up to ISSUE_WIDTH_MAX per cycle.
// Optional same-cycle fetch->decode bypass on an empty queue is enabled by defining IQ_BYPASS_EN.
module instr_fetch_queue #(
  parameter int ISSUE_WIDTH_MAX = 2,
  parameter int FETCH_WIDTH     = 2,
  parameter int DATA_LEN        = 32,
  parameter int IQ_DEPTH        = 8,
  parameter int IQ_DEPTH_CLOG   = $clog2(IQ_DEPTH)
) (
  input  logic                                      clk_free_master,
  input  logic                                      global_rst,
  input  logic [FETCH_WIDTH-1:0]                    fetch_val_if,
  input  logic [FETCH_WIDTH-1:0][DATA_LEN-1:0]      fetch_instr_if,
  output logic                                      fetch_rdy_if,
  input  logic                                      stall_id,
  input  logic                                      flush,
  output logic [ISSUE_WIDTH_MAX-1:0]                instr_val_id,
  output logic [ISSUE_WIDTH_MAX-1:0][DATA_LEN-1:0]  instr_id,
  output logic [IQ_DEPTH_CLOG:0]                    iq_count
);

  localparam int CW    = IQ_DEPTH_CLOG + 1;
  localparam int BYP_W = (ISSUE_WIDTH_MAX < FETCH_WIDTH) ? ISSUE_WIDTH_MAX : FETCH_WIDTH;
  localparam logic [CW-1:0] RDY_MAX = CW'(IQ_DEPTH - FETCH_WIDTH);
  localparam logic [CW-1:0] ISSUE_C = CW'(ISSUE_WIDTH_MAX);

  logic [DATA_LEN-1:0]      mem [IQ_DEPTH];
  logic [IQ_DEPTH_CLOG-1:0] head;
  logic [IQ_DEPTH_CLOG-1:0] tail;
  logic [CW-1:0]            push_n;
  logic [CW-1:0]            push_eff;
  logic [CW-1:0]            pop_n;
  logic [CW-1:0]            avail;
  logic [FETCH_WIDTH-1:0]   wr_mask;
  logic                     out_en;
  logic                     run;

  // Only the contiguous run of valid slots starting at slot 0 counts as a push.
  always_comb begin
    push_n = '0;
    run    = 1'b1;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      run = run & fetch_val_if[i];
      if (run) push_n = CW'(i + 1);
    end
  end

  assign fetch_rdy_if = !global_rst && (iq_count <= RDY_MAX);
  assign push_eff     = fetch_rdy_if ? push_n : '0;
  assign out_en       = !stall_id && !flush && !global_rst;
  assign avail        = (iq_count > ISSUE_C) ? ISSUE_C : iq_count;

  always_comb begin
    instr_val_id = '0;
    instr_id     = '0;
    pop_n        = out_en ? avail : '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_mask[i] = CW'(i) < push_eff;
    end
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
      if (out_en && (CW'(i) < avail)) begin
        instr_val_id[i] = 1'b1;
        instr_id[i]     = mem[head + IQ_DEPTH_CLOG'(i)];
      end
    end
`ifdef IQ_BYPASS_EN
    // Bypassed slots are consumed directly; head and tail both step over them.
    if (out_en && fetch_rdy_if && (iq_count == '0)) begin
      pop_n = (push_eff > ISSUE_C) ? ISSUE_C : push_eff;
      for (int i = 0; i < BYP_W; i++) begin
        if (CW'(i) < pop_n) begin
          instr_val_id[i] = 1'b1;
          instr_id[i]     = fetch_instr_if[i];
          wr_mask[i]      = 1'b0;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk_free_master) begin
    if (global_rst || flush) begin
      head     <= '0;
      tail     <= '0;
      iq_count <= '0;
    end else begin
      head     <= head + pop_n[IQ_DEPTH_CLOG-1:0];
      tail     <= tail + push_eff[IQ_DEPTH_CLOG-1:0];
      iq_count <= iq_count + push_eff - pop_n;
    end
  end

  // Entry storage carries no reset; occupancy is tracked purely by the pointers.
  always_ff @(posedge clk_free_master) begin
    if (!global_rst && !flush) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (wr_mask[i]) mem[tail + IQ_DEPTH_CLOG'(i)] <= fetch_instr_if[i];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized self-checking bench for instr_fetch_queue against a queue-based reference model.
// Honours IQ_BYPASS_EN in the model when the design is built with it.
module tb_instr_fetch_queue;

  logic                  clk_free_master;
  logic                  global_rst;
  logic [1:0]            fetch_val_if;
  logic [1:0][31:0]      fetch_instr_if;
  logic                  fetch_rdy_if;
  logic                  stall_id;
  logic                  flush;
  logic [1:0]            instr_val_id;
  logic [1:0][31:0]      instr_id;
  logic [3:0]            iq_count;

  instr_fetch_queue #(
    .ISSUE_WIDTH_MAX(2), .FETCH_WIDTH(2), .DATA_LEN(32), .IQ_DEPTH(8)
  ) dut (
    .clk_free_master(clk_free_master),
    .global_rst(global_rst),
    .fetch_val_if(fetch_val_if),
    .fetch_instr_if(fetch_instr_if),
    .fetch_rdy_if(fetch_rdy_if),
    .stall_id(stall_id),
    .flush(flush),
    .instr_val_id(instr_val_id),
    .instr_id(instr_id),
    .iq_count(iq_count)
  );

  initial clk_free_master = 1'b0;
  always #5 clk_free_master = ~clk_free_master;

  int total = 0;
  int bad   = 0;

  logic [31:0]      mq[$];
  logic [31:0]      pend[$];
  int               npop;
  logic             cur_fl, cur_rs;
  logic [1:0]       exp_val;
  logic [1:0][31:0] exp_instr;
  logic [3:0]       exp_cnt;
  logic             exp_rdy;

  // Reference model: queue of instructions in program order.
  task automatic drive(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic st, input logic fl, input logic rs);
    int cnt;
    int k;
    logic en;
    @(negedge clk_free_master);
    fetch_val_if      = v;
    fetch_instr_if[0] = a;
    fetch_instr_if[1] = b;
    stall_id          = st;
    flush             = fl;
    global_rst        = rs;
    cur_fl = fl;
    cur_rs = rs;
    cnt = mq.size();
    exp_cnt = 4'(cnt);
    exp_rdy = !rs && ((8 - cnt) >= 2);
    pend.delete();
    if (exp_rdy && v[0]) begin
      pend.push_back(a);
      if (v[1]) pend.push_back(b);
    end
    exp_val = 2'b00;
    exp_instr = '0;
    npop = 0;
    en = !st && !fl && !rs;
`ifdef IQ_BYPASS_EN
    if (en && exp_rdy && cnt == 0) begin
      k = (pend.size() < 2) ? pend.size() : 2;
      for (int i = 0; i < k; i++) begin
        exp_val[i] = 1'b1;
        exp_instr[i] = pend[0];
        void'(pend.pop_front());
      end
      en = 1'b0;
    end
`endif
    if (en) begin
      k = (cnt < 2) ? cnt : 2;
      for (int i = 0; i < k; i++) begin
        exp_val[i] = 1'b1;
        exp_instr[i] = mq[i];
      end
      npop = k;
    end
    #1;
  endtask

  task automatic commit();
    @(posedge clk_free_master);
    if (cur_rs || cur_fl) mq.delete();
    else begin
      repeat (npop) void'(mq.pop_front());
      foreach (pend[i]) mq.push_back(pend[i]);
    end
  endtask

  task automatic test_reset();
    drive(2'b11, $urandom(), $urandom(), 1'b0, 1'b0, 1'b1);
    total++; if (fetch_rdy_if !== 1'b0) begin bad++; $display("[TB] FAIL reset_rdy got=%b want=0", fetch_rdy_if); end
    total++; if (instr_val_id !== 2'b00) begin bad++; $display("[TB] FAIL reset_val got=%b want=00", instr_val_id); end
    total++; if (instr_id !== 64'h0) begin bad++; $display("[TB] FAIL reset_instr got=%h want=0", instr_id); end
    commit();
    drive(2'b11, $urandom(), $urandom(), 1'b0, 1'b0, 1'b1);
    total++; if (fetch_rdy_if !== 1'b0) begin bad++; $display("[TB] FAIL reset_rdy2 got=%b want=0", fetch_rdy_if); end
    total++; if (instr_val_id !== 2'b00) begin bad++; $display("[TB] FAIL reset_val2 got=%b want=00", instr_val_id); end
    total++; if (iq_count !== 4'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d want=0", iq_count); end
    commit();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    total++; if (fetch_rdy_if !== 1'b1) begin bad++; $display("[TB] FAIL release_rdy got=%b want=1", fetch_rdy_if); end
    total++; if (iq_count !== 4'd0) begin bad++; $display("[TB] FAIL release_cnt got=%0d want=0", iq_count); end
    commit();
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 4; k++) begin
      drive((k < 2) ? 2'b11 : 2'b00, $urandom(), $urandom(), 1'b0, 1'b0, 1'b0);
      total++; if (instr_val_id !== exp_val) begin bad++; $display("[TB] FAIL stream_val got=%b want=%b", instr_val_id, exp_val); end
      total++; if (instr_id !== exp_instr) begin bad++; $display("[TB] FAIL stream_instr got=%h want=%h", instr_id, exp_instr); end
      total++; if (iq_count !== exp_cnt) begin bad++; $display("[TB] FAIL stream_cnt got=%0d want=%0d", iq_count, exp_cnt); end
      total++; if (iq_count > 4'd2) begin bad++; $display("[TB] FAIL stream_bound got=%0d want<=2", iq_count); end
      commit();
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < 5; k++) begin
      drive(2'b11, $urandom(), $urandom(), 1'b1, 1'b0, 1'b0);
      total++; if (fetch_rdy_if !== exp_rdy) begin bad++; $display("[TB] FAIL fill_rdy got=%b want=%b", fetch_rdy_if, exp_rdy); end
      total++; if (iq_count !== exp_cnt) begin bad++; $display("[TB] FAIL fill_cnt got=%0d want=%0d", iq_count, exp_cnt); end
      total++; if (instr_val_id !== exp_val) begin bad++; $display("[TB] FAIL fill_val got=%b want=%b", instr_val_id, exp_val); end
      commit();
    end
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    total++; if (iq_count !== 4'd8) begin bad++; $display("[TB] FAIL full_cnt got=%0d want=8", iq_count); end
    total++; if (fetch_rdy_if !== 1'b0) begin bad++; $display("[TB] FAIL full_rdy got=%b want=0", fetch_rdy_if); end
    commit();
    for (int k = 0; k < 5; k++) begin
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      total++; if (fetch_rdy_if !== exp_rdy) begin bad++; $display("[TB] FAIL drain_rdy got=%b want=%b", fetch_rdy_if, exp_rdy); end
      total++; if (instr_val_id !== exp_val) begin bad++; $display("[TB] FAIL drain_val got=%b want=%b", instr_val_id, exp_val); end
      total++; if (instr_id !== exp_instr) begin bad++; $display("[TB] FAIL drain_instr got=%h want=%h", instr_id, exp_instr); end
      total++; if (iq_count !== exp_cnt) begin bad++; $display("[TB] FAIL drain_cnt got=%0d want=%0d", iq_count, exp_cnt); end
      commit();
    end
  endtask

  task automatic test_wrap_partial();
    for (int k = 0; k < 40; k++) begin
      drive((k % 5 == 4) ? 2'b10 : 2'b01, $urandom(), $urandom(), k[0], 1'b0, 1'b0);
      total++; if (instr_val_id !== exp_val) begin bad++; $display("[TB] FAIL wrap_val got=%b want=%b", instr_val_id, exp_val); end
      total++; if (instr_id !== exp_instr) begin bad++; $display("[TB] FAIL wrap_instr got=%h want=%h", instr_id, exp_instr); end
      total++; if (iq_count !== exp_cnt) begin bad++; $display("[TB] FAIL wrap_cnt got=%0d want=%0d", iq_count, exp_cnt); end
      commit();
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 6; k++) begin
      logic [1:0] v;
      logic st;
      v  = (k < 3) ? 2'b00 : ((k == 5) ? 2'b01 : 2'b11);
      st = (k >= 3);
      drive(v, $urandom(), $urandom(), st, 1'b0, 1'b0);
      total++; if (instr_id !== exp_instr) begin bad++; $display("[TB] FAIL preflush_instr got=%h want=%h", instr_id, exp_instr); end
      total++; if (iq_count !== exp_cnt) begin bad++; $display("[TB] FAIL preflush_cnt got=%0d want=%0d", iq_count, exp_cnt); end
      commit();
    end
    drive(2'b11, $urandom(), $urandom(), 1'b0, 1'b1, 1'b0);
    total++; if (iq_count !== 4'd5) begin bad++; $display("[TB] FAIL flush_precnt got=%0d want=5", iq_count); end
    total++; if (instr_val_id !== 2'b00) begin bad++; $display("[TB] FAIL flush_val got=%b want=00", instr_val_id); end
    commit();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    total++; if (iq_count !== 4'd0) begin bad++; $display("[TB] FAIL flush_cnt got=%0d want=0", iq_count); end
    total++; if (instr_val_id !== 2'b00) begin bad++; $display("[TB] FAIL flush_after_val got=%b want=00", instr_val_id); end
    commit();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive(2'($urandom()), $urandom(), $urandom(), $urandom_range(0, 9) < 3,
            $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
      total++; if (fetch_rdy_if !== exp_rdy) begin bad++; $display("[TB] FAIL rand_rdy got=%b want=%b", fetch_rdy_if, exp_rdy); end
      total++; if (instr_val_id !== exp_val) begin bad++; $display("[TB] FAIL rand_val got=%b want=%b", instr_val_id, exp_val); end
      total++; if (instr_id !== exp_instr) begin bad++; $display("[TB] FAIL rand_instr got=%h want=%h", instr_id, exp_instr); end
      total++; if (iq_count !== exp_cnt) begin bad++; $display("[TB] FAIL rand_cnt got=%0d want=%0d", iq_count, exp_cnt); end
      commit();
    end
  endtask

  initial begin
    global_rst     = 1'b1;
    fetch_val_if   = 2'b00;
    fetch_instr_if = '0;
    stall_id       = 1'b0;
    flush          = 1'b0;
    test_reset();
    test_streaming();
    test_full();
    test_wrap_partial();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
